// File: rtl/fabulous_arith_pkg.sv
// fabulous_arith_pkg: shared helpers and types for the segmented FABulous
// add/subtract pipeline.
package fabulous_arith_pkg;

    // A legal split has at least one bit per segment and divides the width exactly.
    function automatic bit seg_cfg_ok(input int width, input int seg_width);
        return (seg_width >= 1) && (width >= seg_width) && ((width % seg_width) == 0);
    endfunction

    // Number of segments (and pipeline latency). Falls back to 1 on an illegal
    // split so elaboration reaches the explicit $error instead of dividing by zero.
    function automatic int calc_nseg(input int width, input int seg_width);
        return seg_cfg_ok(width, seg_width) ? (width / seg_width) : 1;
    endfunction

    // Per-stage control record. At a stage input, carry is the carry-in for
    // that segment; at a stage output, it is the registered carry-out.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_rec_t;

endpackage

// File: rtl/fabulous_pipe_addsub_seg.sv
// fabulous_pipe_addsub_seg: one SEG_WIDTH carry-chain run with its sum and
// carry registers. Inverts operand B itself when the record says subtract.
// With FABULOUS_PIPE_ADDSUB_OVF_EN defined it also registers the signed
// overflow of this segment's MSB (only the top segment's copy is used).
module fabulous_pipe_addsub_seg
    import fabulous_arith_pkg::*;
#(
    parameter int SEG_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic                 en,
    input  stage_rec_t           rec_in,
    input  logic [SEG_WIDTH-1:0] a_seg,
    input  logic [SEG_WIDTH-1:0] b_seg,
    output logic [SEG_WIDTH-1:0] sum_q,
    output stage_rec_t           rec_q
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
    ,
    output logic                 ovf_q
`endif
);

    logic [SEG_WIDTH-1:0] bb;
    logic [SEG_WIDTH:0]   full;

    // Segment add: B is inverted for subtraction, carry-in comes from the record.
    always_comb begin
        bb   = rec_in.sub ? ~b_seg : b_seg;
        full = {1'b0, a_seg} + {1'b0, bb} + {{SEG_WIDTH{1'b0}}, rec_in.carry};
    end

    // Register the segment result and carry; hold everything while stalled.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sum_q <= '0;
            rec_q <= '0;
        end else if (en) begin
            sum_q <= full[SEG_WIDTH-1:0];
            rec_q <= '{valid: rec_in.valid, carry: full[SEG_WIDTH], sub: rec_in.sub};
        end
    end

`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
    // Carry into the MSB recovered from the sum bit, so SEG_WIDTH=1 needs no special case.
    logic c_msb;
    assign c_msb = full[SEG_WIDTH-1] ^ a_seg[SEG_WIDTH-1] ^ bb[SEG_WIDTH-1];

    // Signed overflow = carry into MSB xor carry out of MSB, registered with the sum.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            ovf_q <= 1'b0;
        end else if (en) begin
            ovf_q <= c_msb ^ full[SEG_WIDTH];
        end
    end
`endif

endmodule

// File: rtl/fabulous_pipe_addsub.sv
// fabulous_pipe_addsub: pipelined WIDTH-bit add/subtract, one SEG_WIDTH
// carry-chain run per stage with the carry registered between stages.
// Latency NSEG = WIDTH/SEG_WIDTH cycles, one operation per cycle, global stall.
// Optional macro FABULOUS_PIPE_ADDSUB_OVF_EN adds a registered signed-overflow
// output ovf aligned with y.
module fabulous_pipe_addsub
    import fabulous_arith_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             co
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = calc_nseg(WIDTH, SEG_WIDTH);

    if (!seg_cfg_ok(WIDTH, SEG_WIDTH)) begin : g_bad_cfg
        $error("fabulous_pipe_addsub: WIDTH must be a positive multiple of SEG_WIDTH (SEG_WIDTH >= 1)");
    end

    logic       advance;
    stage_rec_t rec_q [NSEG];
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
    logic       ovf_seg [NSEG];
`endif

    // The whole pipeline moves together unless a finished result is being held.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = rec_q[NSEG-1].valid;
    assign co        = rec_q[NSEG-1].carry;
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
    assign ovf       = ovf_seg[NSEG-1];
`endif

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        logic [SEG_WIDTH-1:0] a_k;
        logic [SEG_WIDTH-1:0] b_k;
        logic [SEG_WIDTH-1:0] sum_k;
        stage_rec_t           rec_in_k;

        if (k == 0) begin : g_first
            // Subtract forces carry-in to 1 and ignores ci.
            assign a_k      = a[SEG_WIDTH-1:0];
            assign b_k      = b[SEG_WIDTH-1:0];
            assign rec_in_k = '{valid: in_valid, carry: sub | ci, sub: sub};
        end else begin : g_skew
            logic [SEG_WIDTH-1:0] a_dl [k];
            logic [SEG_WIDTH-1:0] b_dl [k];

            // Delay operand segment k by k cycles so it meets stage k-1's carry.
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    for (int d = 0; d < k; d++) begin
                        a_dl[d] <= '0;
                        b_dl[d] <= '0;
                    end
                end else if (advance) begin
                    a_dl[0] <= a[k*SEG_WIDTH +: SEG_WIDTH];
                    b_dl[0] <= b[k*SEG_WIDTH +: SEG_WIDTH];
                    for (int d = 1; d < k; d++) begin
                        a_dl[d] <= a_dl[d-1];
                        b_dl[d] <= b_dl[d-1];
                    end
                end
            end

            assign a_k      = a_dl[k-1];
            assign b_k      = b_dl[k-1];
            assign rec_in_k = rec_q[k-1];
        end

        fabulous_pipe_addsub_seg #(
            .SEG_WIDTH (SEG_WIDTH)
        ) u_seg (
            .CLK    (CLK),
            .RESETN (RESETN),
            .en     (advance),
            .rec_in (rec_in_k),
            .a_seg  (a_k),
            .b_seg  (b_k),
            .sum_q  (sum_k),
            .rec_q  (rec_q[k])
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
            ,
            .ovf_q  (ovf_seg[k])
`endif
        );

        if (k == NSEG - 1) begin : g_top
            assign y[k*SEG_WIDTH +: SEG_WIDTH] = sum_k;
        end else begin : g_deskew
            localparam int DLY = NSEG - 1 - k;
            logic [SEG_WIDTH-1:0] dsk [DLY];

            // Hold finished low segments until the top segment catches up.
            always_ff @(posedge CLK or negedge RESETN) begin
                if (!RESETN) begin
                    for (int d = 0; d < DLY; d++) begin
                        dsk[d] <= '0;
                    end
                end else if (advance) begin
                    dsk[0] <= sum_k;
                    for (int d = 1; d < DLY; d++) begin
                        dsk[d] <= dsk[d-1];
                    end
                end
            end

            assign y[k*SEG_WIDTH +: SEG_WIDTH] = dsk[DLY-1];
        end
    end

endmodule

// File: tb/tb_fabulous_pipe_addsub.sv
// tb_fabulous_pipe_addsub: table vectors, random stream with back-pressure,
// mid-flight reset, and a single-segment instance.
module tb_fabulous_pipe_addsub;

    localparam int W  = 32;
    localparam int NS = 4;

    logic         CLK = 1'b0;
    logic         RESETN = 1'b0;
    logic         in_valid, in_ready, sub, ci, out_valid, out_ready, co;
    logic [W-1:0] a, b, y;
    logic         in_valid2, in_ready2, sub2, ci2, out_valid2, out_ready2, co2;
    logic [7:0]   a2, b2, y2;
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
    logic         ovf, ovf2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    fabulous_pipe_addsub #(.WIDTH(W), .SEG_WIDTH(8)) dut (
        .CLK(CLK), .RESETN(RESETN), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .ci(ci), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .co(co)
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    fabulous_pipe_addsub #(.WIDTH(8), .SEG_WIDTH(8)) dut1 (
        .CLK(CLK), .RESETN(RESETN), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .sub(sub2), .ci(ci2), .out_valid(out_valid2),
        .out_ready(out_ready2), .y(y2), .co(co2)
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
        , .ovf(ovf2)
`endif
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         ci;
        logic [W-1:0] ey;
        logic         eco;
        logic         eovf;
    } vec_t;

    vec_t         vt [8];
    logic [W+1:0] exp_q [$];

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference: plain integer arithmetic on the mathematical values. Returns {ovf, co, y}.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] z,
                                            input logic s, input logic c);
        longint ux, uz, us, sx, sz, ss;
        logic   cout, v;
        ux = longint'({32'h0, x});
        uz = longint'({32'h0, z});
        sx = longint'($signed(x));
        sz = longint'($signed(z));
        if (s) begin
            us   = ux - uz;
            cout = (ux >= uz);
            ss   = sx - sz;
        end else begin
            us   = ux + uz + longint'(c);
            cout = (us >= 64'sh1_0000_0000);
            ss   = sx + sz + longint'(c);
        end
        v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        return {v, cout, us[W-1:0]};
    endfunction

    task automatic run_one(input vec_t v, input string nm);
        int n;
        a = v.a; b = v.b; sub = v.sub; ci = v.ci; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check({nm, " latency"}, n, NS - 1);
        check({nm, " y"}, y, v.ey);
        check({nm, " co"}, co, v.eco);
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
        check({nm, " ovf"}, ovf, v.eovf);
`endif
        step();
    endtask

    initial begin
        logic [W+1:0] e;
        logic [W:0]   held;
        logic         held_v, stale;
        int           sent, got, cyc, n;
        vec_t         rv;

        vt[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vt[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vt[2] = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0};
        vt[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vt[4] = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1};
        vt[5] = '{32'h00000005, 32'h00000003, 1'b1, 1'b0, 32'h00000002, 1'b1, 1'b0};
        vt[6] = '{32'h12345678, 32'h0000FFFF, 1'b0, 1'b1, 32'h12355678, 1'b0, 1'b0};
        vt[7] = '{32'h00000010, 32'h00000010, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0};

        in_valid = 0; a = '0; b = '0; sub = 0; ci = 0; out_ready = 1;
        in_valid2 = 0; a2 = '0; b2 = '0; sub2 = 0; ci2 = 0; out_ready2 = 1;

        // Reset state
        step(); step();
        check("reset out_valid", out_valid, 0);
        check("reset y", y, 0);
        check("reset co", co, 0);
        check("reset out_valid nseg1", out_valid2, 0);
        RESETN = 1'b1;
        step();
        check("in_ready after release", in_ready, 1);

        // Table vectors, one at a time
        for (int i = 0; i < 8; i++) run_one(vt[i], $sformatf("vec%0d", i));

        // Random singles against the model
        for (int i = 0; i < 4; i++) begin
            rv.a = $urandom; rv.b = $urandom; rv.sub = 1'($urandom); rv.ci = 1'($urandom);
            e = ref_op(rv.a, rv.b, rv.sub, rv.ci);
            rv.ey = e[W-1:0]; rv.eco = e[W]; rv.eovf = e[W+1];
            run_one(rv, $sformatf("rand%0d", i));
        end

        // Back-to-back: results on consecutive cycles
        a = vt[1].a; b = vt[1].b; sub = vt[1].sub; ci = vt[1].ci; in_valid = 1;
        step();
        a = vt[2].a; b = vt[2].b; sub = vt[2].sub; ci = vt[2].ci;
        step();
        in_valid = 0;
        n = 0;
        while (!out_valid && n < 20) begin step(); n++; end
        check("b2b first latency", n, NS - 2);
        check("b2b first y/co", {co, y}, {1'b1, 32'h00000000});
        step();
        check("b2b second valid", out_valid, 1);
        check("b2b second y/co", {co, y}, {1'b0, 32'hFFFFFFFF});
        step();

        // Random stream with out_ready pattern 1,0,0,1
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; held_v = 0; held = '0;
        while (got < 12 && cyc < 300) begin
            if (held_v) begin
                check("stall valid held", out_valid, 1);
                check("stall y/co held", {co, y}, held);
            end
            out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            in_valid  = (sent < 12);
            a = $urandom; b = $urandom; sub = 1'($urandom); ci = 1'($urandom);
            #1;
            check("in_ready advance", in_ready, !out_valid || out_ready);
            held_v = out_valid && !out_ready;
            held   = {co, y};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream unexpected result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("stream y/co #%0d", got), {co, y}, e[W:0]);
`ifdef FABULOUS_PIPE_ADDSUB_OVF_EN
                    check($sformatf("stream ovf #%0d", got), ovf, e[W+1]);
`endif
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_op(a, b, sub, ci));
                sent++;
            end
            step();
            cyc++;
        end
        check("stream results received", got, 12);
        in_valid = 0; out_ready = 1;
        step();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            a = 32'h01010101 * (i + 1); b = 32'h00100010; sub = 0; ci = 0; in_valid = 1;
            step();
        end
        in_valid = 0;
        step();
        check("pre-reset valid", out_valid, 1);
        #1;
        RESETN = 1'b0;
        #1;
        check("async reset out_valid", out_valid, 0);
        check("async reset y", y, 0);
        check("async reset co", co, 0);
        step(); step();
        RESETN = 1'b1;
        step();
        check("post-reset in_ready", in_ready, 1);
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) stale = 1;
            step();
        end
        check("no stale result", stale, 0);
        run_one(vt[0], "post-reset");

        // Single-segment instance: latency 1
        a2 = 8'hF0; b2 = 8'h20; sub2 = 0; ci2 = 0; in_valid2 = 1;
        step();
        a2 = 8'h10; b2 = 8'h20; sub2 = 1;
        check("nseg1 add valid", out_valid2, 1);
        check("nseg1 add y/co", {co2, y2}, {1'b1, 8'h10});
        step();
        in_valid2 = 0;
        check("nseg1 sub valid", out_valid2, 1);
        check("nseg1 sub y/co", {co2, y2}, {1'b0, 8'hF0});
        step();
        check("nseg1 drained", out_valid2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
